// File: rtl/game_sprite_bounce_control.sv
// Motion supervisor for one sprite. It drives the load strobes, position/speed
// data and update enable of the sprite register block. It launches the sprite,
// reflects it at the playfield edges, freezes it on collision, and respawns it
// after a delay until no lives remain.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped, waiting for launch
// LOAD  | one cycle: start position and speed strobed into register block
// RUN   | motion enabled, wall bounces reflect speed
// DEAD  | frozen after collision, respawn delay counting down
// OVER  | out of lives, waiting for launch

`ifndef X_WIDTH
`define X_WIDTH 10
`endif
`ifndef Y_WIDTH
`define Y_WIDTH 9
`endif

module game_sprite_bounce_control #(
  parameter int DX_WIDTH       = 2,
  parameter int DY_WIDTH       = 2,
  parameter int START_X        = 0,
  parameter int START_Y        = 0,
  parameter int START_DX       = 1,
  parameter int START_DY       = 1,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 639,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 479,
  parameter int RESPAWN_CYCLES = 1000000,
  parameter int LIVES          = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  launch,
  input  logic                  halt,
  input  logic                  collision,
  input  logic [`X_WIDTH-1:0]   sprite_x,
  input  logic [`Y_WIDTH-1:0]   sprite_y,
  output logic                  sprite_write_xy,
  output logic                  sprite_write_dxy,
  output logic [`X_WIDTH-1:0]   sprite_write_x,
  output logic [`Y_WIDTH-1:0]   sprite_write_y,
  output logic [DX_WIDTH-1:0]   sprite_write_dx,
  output logic [DY_WIDTH-1:0]   sprite_write_dy,
  output logic                  sprite_enable_update,
  output logic [3:0]            lives_left,
  output logic [7:0]            bounce_count,
  output logic [2:0]            state
);

  localparam int XW = `X_WIDTH;
  localparam int YW = `Y_WIDTH;

  localparam logic [XW-1:0]       X_MIN_C    = XW'(X_MIN);
  localparam logic [XW-1:0]       X_MAX_C    = XW'(X_MAX);
  localparam logic [YW-1:0]       Y_MIN_C    = YW'(Y_MIN);
  localparam logic [YW-1:0]       Y_MAX_C    = YW'(Y_MAX);
  localparam logic [XW-1:0]       START_X_C  = XW'(START_X);
  localparam logic [YW-1:0]       START_Y_C  = YW'(START_Y);
  localparam logic [DX_WIDTH-1:0] START_DX_C = DX_WIDTH'(START_DX);
  localparam logic [DY_WIDTH-1:0] START_DY_C = DY_WIDTH'(START_DY);
  localparam logic [23:0]         RESPAWN_C  = 24'(RESPAWN_CYCLES - 1);
  localparam logic [3:0]          LIVES_C    = 4'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DEAD = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 wr_xy_q, wr_xy_d;
  logic                 wr_dxy_q, wr_dxy_d;
  logic [XW-1:0]        wr_x_q, wr_x_d;
  logic [YW-1:0]        wr_y_q, wr_y_d;
  logic [DX_WIDTH-1:0]  wr_dx_q, wr_dx_d;
  logic [DY_WIDTH-1:0]  wr_dy_q, wr_dy_d;
  logic                 en_q, en_d;
  logic [3:0]           lives_q, lives_d;
  logic [7:0]           bounce_q, bounce_d;
  logic [DX_WIDTH-1:0]  dx_q, dx_d;
  logic [DY_WIDTH-1:0]  dy_q, dy_d;
  logic [23:0]          cnt_q, cnt_d;

  logic dx_pos, dx_neg, dy_pos, dy_neg;
  logic bounce_x, bounce_y;

  // Reflection saturates: the most-negative speed maps to the most-positive.
  function automatic logic [DX_WIDTH-1:0] neg_dx(input logic [DX_WIDTH-1:0] v);
    if (v == {1'b1, {(DX_WIDTH-1){1'b0}}}) neg_dx = {1'b0, {(DX_WIDTH-1){1'b1}}};
    else                                    neg_dx = -v;
  endfunction

  function automatic logic [DY_WIDTH-1:0] neg_dy(input logic [DY_WIDTH-1:0] v);
    if (v == {1'b1, {(DY_WIDTH-1){1'b0}}}) neg_dy = {1'b0, {(DY_WIDTH-1){1'b1}}};
    else                                    neg_dy = -v;
  endfunction

  // Wall detection: unsigned position compare against the mirrored speed sign.
  always_comb begin
    dx_pos   = ~dx_q[DX_WIDTH-1] & (|dx_q);
    dx_neg   = dx_q[DX_WIDTH-1];
    dy_pos   = ~dy_q[DY_WIDTH-1] & (|dy_q);
    dy_neg   = dy_q[DY_WIDTH-1];
    bounce_x = ((sprite_x >= X_MAX_C) && dx_pos) || ((sprite_x <= X_MIN_C) && dx_neg);
    bounce_y = ((sprite_y >= Y_MAX_C) && dy_pos) || ((sprite_y <= Y_MIN_C) && dy_neg);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    wr_xy_d  = 1'b0;
    wr_dxy_d = 1'b0;
    wr_x_d   = wr_x_q;
    wr_y_d   = wr_y_q;
    wr_dx_d  = wr_dx_q;
    wr_dy_d  = wr_dy_q;
    lives_d  = lives_q;
    bounce_d = bounce_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (launch) begin
          state_d  = S_LOAD;
          lives_d  = LIVES_C;
          bounce_d = 8'd0;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (collision) begin
          state_d = S_DEAD;
          lives_d = lives_q - 4'd1;
          cnt_d   = RESPAWN_C;
        end else if (bounce_x || bounce_y) begin
          wr_dxy_d = 1'b1;
          wr_dx_d  = bounce_x ? neg_dx(dx_q) : dx_q;
          wr_dy_d  = bounce_y ? neg_dy(dy_q) : dy_q;
          dx_d     = wr_dx_d;
          dy_d     = wr_dy_d;
          bounce_d = bounce_q + 8'd1;
        end
      end
      S_DEAD: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (cnt_q == 24'd0) begin
          state_d = (lives_q != 4'd0) ? S_LOAD : S_OVER;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering LOAD strobes the start values so they are present during LOAD.
    if (state_d == S_LOAD) begin
      wr_xy_d  = 1'b1;
      wr_dxy_d = 1'b1;
      wr_x_d   = START_X_C;
      wr_y_d   = START_Y_C;
      wr_dx_d  = START_DX_C;
      wr_dy_d  = START_DY_C;
      dx_d     = START_DX_C;
      dy_d     = START_DY_C;
    end

    en_d = (state_d == S_RUN);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_xy_q  <= 1'b0;
      wr_dxy_q <= 1'b0;
      wr_x_q   <= '0;
      wr_y_q   <= '0;
      wr_dx_q  <= '0;
      wr_dy_q  <= '0;
      en_q     <= 1'b0;
      lives_q  <= 4'd0;
      bounce_q <= 8'd0;
      dx_q     <= '0;
      dy_q     <= '0;
      cnt_q    <= 24'd0;
    end else begin
      state_q  <= state_d;
      wr_xy_q  <= wr_xy_d;
      wr_dxy_q <= wr_dxy_d;
      wr_x_q   <= wr_x_d;
      wr_y_q   <= wr_y_d;
      wr_dx_q  <= wr_dx_d;
      wr_dy_q  <= wr_dy_d;
      en_q     <= en_d;
      lives_q  <= lives_d;
      bounce_q <= bounce_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign state                = state_q;
  assign sprite_write_xy      = wr_xy_q;
  assign sprite_write_dxy     = wr_dxy_q;
  assign sprite_write_x       = wr_x_q;
  assign sprite_write_y       = wr_y_q;
  assign sprite_write_dx      = wr_dx_q;
  assign sprite_write_dy      = wr_dy_q;
  assign sprite_enable_update = en_q;
  assign lives_left           = lives_q;
  assign bounce_count         = bounce_q;

endmodule

// File: tb/tb_game_sprite_bounce_control.sv
// Scoreboard bench: the stimulus sequence queues the expected snapshot of
// every output event (state change or strobe); monitors pop and compare.
module tb_game_sprite_bounce_control;

  typedef struct packed {
    logic [2:0] st;
    logic       xy;
    logic       dxy;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] dx;
    logic [1:0] dy;
    logic       en;
    logic [3:0] lives;
    logic [7:0] bc;
  } ev_t;

  typedef struct packed {
    logic       xy;
    logic       dxy;
    logic [1:0] dx;
    logic [1:0] dy;
    logic [7:0] bc;
  } nev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       launch, halt, collision;
  logic [9:0] sprite_x;
  logic [8:0] sprite_y;
  logic       wr_xy, wr_dxy, en;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [1:0] wr_dx, wr_dy;
  logic [3:0] lives;
  logic [7:0] bc;
  logic [2:0] st;

  logic       n_launch;
  logic [9:0] n_x;
  logic [8:0] n_y;
  logic       n_wr_xy, n_wr_dxy, n_en;
  logic [9:0] n_wr_x;
  logic [8:0] n_wr_y;
  logic [1:0] n_wr_dx, n_wr_dy;
  logic [3:0] n_lives;
  logic [7:0] n_bc;
  logic [2:0] n_st;

  int   tests = 0;
  int   fails = 0;
  ev_t  exp_q[$];
  nev_t nexp_q[$];

  always #5 clk = ~clk;

  game_sprite_bounce_control #(
    .START_X(100), .START_Y(50), .START_DX(1), .START_DY(1), .RESPAWN_CYCLES(4), .LIVES(3)
  ) u_dut (
    .clk(clk), .reset(reset), .launch(launch), .halt(halt), .collision(collision),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_write_xy(wr_xy), .sprite_write_dxy(wr_dxy),
    .sprite_write_x(wr_x), .sprite_write_y(wr_y),
    .sprite_write_dx(wr_dx), .sprite_write_dy(wr_dy),
    .sprite_enable_update(en), .lives_left(lives), .bounce_count(bc), .state(st)
  );

  game_sprite_bounce_control #(
    .START_X(5), .START_Y(5), .START_DX(-2), .START_DY(0), .RESPAWN_CYCLES(4), .LIVES(3)
  ) u_neg (
    .clk(clk), .reset(reset), .launch(n_launch), .halt(1'b0), .collision(1'b0),
    .sprite_x(n_x), .sprite_y(n_y),
    .sprite_write_xy(n_wr_xy), .sprite_write_dxy(n_wr_dxy),
    .sprite_write_x(n_wr_x), .sprite_write_y(n_wr_y),
    .sprite_write_dx(n_wr_dx), .sprite_write_dy(n_wr_dy),
    .sprite_enable_update(n_en), .lives_left(n_lives), .bounce_count(n_bc), .state(n_st)
  );

  function automatic ev_t snap();
    snap = '{st: st, xy: wr_xy, dxy: wr_dxy, x: wr_x, y: wr_y, dx: wr_dx, dy: wr_dy,
             en: en, lives: lives, bc: bc};
  endfunction

  task automatic show_fail(input string name, input ev_t g, input ev_t e);
    $display("FAIL %s: got st=%0d xy=%0b dxy=%0b x=%0d y=%0d dx=%b dy=%b en=%0b lives=%0d bc=%0d; exp st=%0d xy=%0b dxy=%0b x=%0d y=%0d dx=%b dy=%b en=%0b lives=%0d bc=%0d",
             name, g.st, g.xy, g.dxy, g.x, g.y, g.dx, g.dy, g.en, g.lives, g.bc,
             e.st, e.xy, e.dxy, e.x, e.y, e.dx, e.dy, e.en, e.lives, e.bc);
  endtask

  task automatic push(input logic [2:0] s, input logic xy, input logic dxy,
                      input logic [1:0] dx, input logic [1:0] dy, input logic e,
                      input logic [3:0] l, input logic [7:0] b);
    exp_q.push_back('{st: s, xy: xy, dxy: dxy, x: 10'd100, y: 9'd50, dx: dx, dy: dy,
                      en: e, lives: l, bc: b});
  endtask

  task automatic npush(input logic xy, input logic [1:0] dx, input logic [1:0] dy,
                       input logic [7:0] b);
    nexp_q.push_back('{xy: xy, dxy: 1'b1, dx: dx, dy: dy, bc: b});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    ev_t g;
    g = snap();
    tests++;
    if (g !== '0) begin
      fails++;
      show_fail(name, g, '0);
    end
  endtask

  // Main DUT monitor: any state change or strobe is an event to match.
  initial begin
    logic [2:0] prev;
    ev_t g, e;
    int  n;
    prev = 3'd0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!reset && (st !== prev || wr_xy || wr_dxy)) begin
        g = snap();
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          show_fail($sformatf("main_unexpected_evt%0d", n), g, '0);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            fails++;
            show_fail($sformatf("main_evt%0d", n), g, e);
          end
        end
        n++;
      end
      prev = st;
    end
  end

  // Most-negative-speed DUT monitor: strobes only.
  initial begin
    nev_t g, e;
    int   n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!reset && (n_wr_xy || n_wr_dxy)) begin
        g = '{xy: n_wr_xy, dxy: n_wr_dxy, dx: n_wr_dx, dy: n_wr_dy, bc: n_bc};
        tests++;
        if (nexp_q.size() == 0) begin
          fails++;
          $display("FAIL neg_unexpected_evt%0d: got xy=%0b dxy=%0b dx=%b dy=%b bc=%0d",
                   n, g.xy, g.dxy, g.dx, g.dy, g.bc);
        end else begin
          e = nexp_q.pop_front();
          if (g !== e) begin
            fails++;
            $display("FAIL neg_evt%0d: got xy=%0b dxy=%0b dx=%b dy=%b bc=%0d; exp xy=%0b dxy=%0b dx=%b dy=%b bc=%0d",
                     n, g.xy, g.dxy, g.dx, g.dy, g.bc, e.xy, e.dxy, e.dx, e.dy, e.bc);
          end
        end
        n++;
      end
    end
  end

  task automatic respawn(input logic [3:0] l, input logic [7:0] b);
    repeat (3) tick();
    push(3'd1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, l, b);
    tick();
    push(3'd2, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, l, b);
    tick();
  endtask

  task automatic collide(input logic [3:0] l, input logic [7:0] b);
    sprite_x = 10'd639;
    collision = 1'b1;
    push(3'd3, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, l, b);
    tick();
    collision = 1'b0;
    sprite_x = 10'd300;
  endtask

  initial begin
    reset = 1'b1;
    launch = 1'b0; halt = 1'b0; collision = 1'b0;
    sprite_x = 10'd300; sprite_y = 9'd200;
    n_launch = 1'b0; n_x = 10'd300; n_y = 9'd200;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b0;

    // launch -> LOAD -> RUN
    launch = 1'b1;
    push(3'd1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 4'd3, 8'd0);
    tick();
    launch = 1'b0;
    push(3'd2, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 4'd3, 8'd0);
    tick();
    launch = 1'b1;            // ignored in RUN
    repeat (2) tick();
    launch = 1'b0;

    // right wall, then hold at the wall: no second strobe
    sprite_x = 10'd639;
    push(3'd2, 1'b0, 1'b1, 2'b11, 2'b01, 1'b1, 4'd3, 8'd1);
    tick();
    repeat (3) tick();

    // bottom wall with dx=-1 kept
    sprite_x = 10'd300; sprite_y = 9'd479;
    push(3'd2, 1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 4'd3, 8'd2);
    tick();

    // corner: both axes flip, single increment
    sprite_x = 10'd0; sprite_y = 9'd0;
    push(3'd2, 1'b0, 1'b1, 2'b01, 2'b01, 1'b1, 4'd3, 8'd3);
    tick();
    repeat (2) tick();
    sprite_y = 9'd200;

    // collision beats a simultaneous wall bounce; respawn until OVER
    collide(4'd2, 8'd3);
    respawn(4'd2, 8'd3);
    collide(4'd1, 8'd3);
    respawn(4'd1, 8'd3);
    collide(4'd0, 8'd3);
    repeat (3) tick();
    push(3'd4, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 4'd0, 8'd3);
    tick();
    repeat (2) tick();

    // relaunch from OVER
    launch = 1'b1;
    push(3'd1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 4'd3, 8'd0);
    tick();
    launch = 1'b0;
    push(3'd2, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 4'd3, 8'd0);
    tick();

    // halt beats collision and launch in RUN
    launch = 1'b1; halt = 1'b1; collision = 1'b1;
    push(3'd0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 4'd3, 8'd0);
    tick();
    launch = 1'b0; halt = 1'b0; collision = 1'b0;
    repeat (2) tick();

    // async reset in the middle of DEAD
    launch = 1'b1;
    push(3'd1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 4'd3, 8'd0);
    tick();
    launch = 1'b0;
    push(3'd2, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 4'd3, 8'd0);
    tick();
    collide(4'd2, 8'd0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset_mid_dead");
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // most-negative speed DUT: -2 reflects to +1; zero dy never bounces
    n_launch = 1'b1;
    npush(1'b1, 2'b10, 2'b00, 8'd0);
    tick();
    n_launch = 1'b0;
    tick();
    n_x = 10'd0; n_y = 9'd0;
    npush(1'b0, 2'b01, 2'b00, 8'd1);
    tick();
    repeat (2) tick();
    n_x = 10'd639;
    npush(1'b0, 2'b11, 2'b00, 8'd2);
    tick();
    repeat (3) tick();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL main_queue_drained: got %0d pending, exp 0", exp_q.size());
    end
    tests++;
    if (nexp_q.size() != 0) begin
      fails++;
      $display("FAIL neg_queue_drained: got %0d pending, exp 0", nexp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
